// File: rtl/tc_program_loader8_if.sv
// Host-side load handshake plus the CPU fetch port of the 8-bit program memory.
// Master drives stream/fetch requests; slave is the loader.
interface tc_program_loader8_if;
    logic       load_start;
    logic [8:0] load_len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] address;
    logic [7:0] out;

    modport master (
        output load_start, load_len, in_valid, in_data, address,
        input  in_ready, busy, done, err, out
    );

    modport slave (
        input  load_start, load_len, in_valid, in_data, address,
        output in_ready, busy, done, err, out
    );
endinterface

// File: rtl/tc_program_loader8.sv
// Streams a byte sequence into a DEPTHx8 program RAM over valid/ready and
// exposes the ROM-compatible combinational fetch port (zero under reset or load).
module tc_program_loader8 #(
    parameter int unsigned DEPTH = 256
) (
    input logic                 clk,
    input logic                 rst,
    tc_program_loader8_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wr_ptr_q, wr_ptr_d;
    logic [8:0] remaining_q, remaining_d;
    logic       err_q, err_d;
    logic       wr_en;
    logic       len_ok;
    logic       busy_int;
    logic       addr_in_range;

    // Contents survive rst; zero only at power-up.
    logic [7:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    always_comb begin
        len_ok      = (bus.load_len != '0) && (bus.load_len <= 9'(DEPTH));
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    if (len_ok) begin
                        state_d     = ST_LOAD;
                        wr_ptr_d    = '0;
                        remaining_d = bus.load_len;
                        err_d       = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    wr_en       = !rst;
                    wr_ptr_d    = wr_ptr_q + 8'd1;
                    remaining_d = remaining_q - 9'd1;
                    if (remaining_q == 9'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == ST_LOAD);
        busy_int     = (state_q != ST_IDLE);
        bus.busy     = busy_int;
        bus.done     = (state_q == ST_DONE);
        bus.err      = err_q;
    end

    // Fetch port: locations beyond DEPTH read as zero.
    always_comb begin
        addr_in_range = ({1'b0, bus.address} < 9'(DEPTH));
        bus.out       = '0;
        if (!rst && !busy_int && addr_in_range) begin
            bus.out = mem_q[bus.address[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_tc_program_loader8.sv
// Randomized scoreboard bench for tc_program_loader8: stimulus pushes expected
// observations with their cycle stamp, a negedge monitor pops and compares.
module tb_tc_program_loader8;
    localparam int K_OUT = 0, K_RDY = 1, K_BUSY = 2, K_ERR = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int vectors    = 0;
    int miscompares = 0;

    chk_t       chk_q[$];
    int         done_q[$];
    logic [7:0] mem_m [256];
    logic [7:0] stim_data[$];
    bit         stim_valid[$];

    tc_program_loader8_if bus();

    tc_program_loader8 #(.DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            K_OUT:   return "out";
            K_RDY:   return "in_ready";
            K_BUSY:  return "busy";
            default: return "err";
        endcase
    endfunction

    function automatic void expect_val(input int kind, input logic [7:0] exp);
        chk_t c;
        c.cyc  = cyc;
        c.kind = kind;
        c.exp  = exp;
        chk_q.push_back(c);
    endfunction

    // Monitor: compares done every cycle and drains stamped expectations.
    always @(negedge clk) begin
        bit         exp_done;
        chk_t       c;
        logic [7:0] act;
        while (done_q.size() > 0 && done_q[0] < cyc) begin
            void'(done_q.pop_front());
        end
        exp_done = (done_q.size() > 0 && done_q[0] == cyc);
        if (exp_done) void'(done_q.pop_front());
        vectors++;
        if (bus.done !== exp_done) begin
            miscompares++;
            $display("FAIL done @cyc %0d: got %b expected %b", cyc, bus.done, exp_done);
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            case (c.kind)
                K_OUT:   act = bus.out;
                K_RDY:   act = {7'b0, bus.in_ready};
                K_BUSY:  act = {7'b0, bus.busy};
                default: act = {7'b0, bus.err};
            endcase
            vectors++;
            if (c.cyc != cyc || act !== c.exp) begin
                miscompares++;
                $display("FAIL %s @cyc %0d (stamp %0d): got %h expected %h",
                         kind_name(c.kind), cyc, c.cyc, act, c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [7:0] a);
        step();
        bus.address = a;
        expect_val(K_OUT, mem_m[a]);
        expect_val(K_BUSY, 8'd0);
    endtask

    // Starts a load of len bytes, sends the first `beats` of stim_data.
    // stim_valid supplies an explicit valid pattern first, then random gaps.
    task automatic load_stream(input int len, input int beats, input bit poke);
        int ptr  = 0;
        int sent = 0;
        int gap  = 0;
        int pi   = 0;
        bit v;
        step();
        bus.load_start = 1'b1;
        bus.load_len   = 9'(len);
        bus.in_valid   = 1'b0;
        expect_val(K_RDY, 8'd0);
        step();
        bus.load_start = 1'b0;
        while (sent < beats) begin
            if (pi < stim_valid.size()) v = stim_valid[pi];
            else v = ($urandom_range(0, 3) != 0) || (gap >= 4);
            pi++;
            bus.in_valid = v;
            bus.in_data  = v ? stim_data[sent] : 8'($urandom);
            bus.address  = 8'($urandom);
            if (poke) begin
                bus.load_start = ($urandom_range(0, 7) == 0);
                bus.load_len   = 9'($urandom_range(0, 300));
            end
            expect_val(K_RDY, 8'd1);
            expect_val(K_BUSY, 8'd1);
            expect_val(K_OUT, 8'd0);
            expect_val(K_ERR, 8'd0);
            if (v) begin
                mem_m[ptr] = stim_data[sent];
                ptr  = (ptr + 1) % 256;
                sent++;
                gap  = 0;
                if (sent == len) done_q.push_back(cyc + 1);
            end else begin
                gap++;
            end
            step();
        end
        bus.in_valid   = 1'b0;
        bus.load_start = 1'b0;
        if (beats == len) begin
            bus.load_start = poke;
            expect_val(K_RDY, 8'd0);
            expect_val(K_BUSY, 8'd1);
            step();
            bus.load_start = 1'b0;
            expect_val(K_BUSY, 8'd0);
            expect_val(K_RDY, 8'd0);
        end
    endtask

    task automatic illegal(input int len);
        step();
        bus.load_start = 1'b1;
        bus.load_len   = 9'(len);
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'($urandom);
        step();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        expect_val(K_ERR, 8'd1);
        expect_val(K_RDY, 8'd0);
        expect_val(K_BUSY, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.address    = '0;
        rst = 1'b1;
        step();
        step();
        expect_val(K_OUT, 8'd0);
        expect_val(K_RDY, 8'd0);
        expect_val(K_BUSY, 8'd0);
        expect_val(K_ERR, 8'd0);
        step();
        rst = 1'b0;

        // Back-to-back 4-byte load.
        stim_data  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        stim_valid = '{1, 1, 1, 1};
        load_stream(4, 4, 1'b0);
        for (int a = 0; a <= 4; a++) read_chk(8'(a));

        // Gappy 3-byte load.
        stim_data  = '{8'h11, 8'h22, 8'h33};
        stim_valid = '{1, 0, 0, 1, 0, 1};
        load_stream(3, 3, 1'b0);
        for (int a = 0; a <= 3; a++) read_chk(8'(a));

        // Illegal lengths, then a legal one clears err.
        illegal(0);
        illegal(257);
        read_chk(8'h00);
        stim_data  = '{8'h5A};
        stim_valid = '{};
        load_stream(1, 1, 1'b0);
        read_chk(8'h00);
        read_chk(8'h01);

        // Full-depth load with stray load_start pokes.
        stim_data  = '{};
        stim_valid = '{};
        for (int i = 0; i < 256; i++) stim_data.push_back(8'(i));
        load_stream(256, 256, 1'b1);
        read_chk(8'hFF);
        for (int i = 0; i < 6; i++) read_chk(8'($urandom));

        // Preload, then reset mid-load with a simultaneous load_start.
        stim_data  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        stim_valid = '{1, 1, 1, 1};
        load_stream(4, 4, 1'b0);
        stim_data  = '{8'hEE, 8'hEF};
        stim_valid = '{1, 1};
        load_stream(4, 2, 1'b0);
        rst            = 1'b1;
        bus.load_start = 1'b1;
        bus.load_len   = 9'd3;
        bus.address    = 8'h02;
        expect_val(K_OUT, 8'd0);
        step();
        expect_val(K_RDY, 8'd0);
        expect_val(K_BUSY, 8'd0);
        expect_val(K_OUT, 8'd0);
        step();
        rst            = 1'b0;
        bus.load_start = 1'b0;
        expect_val(K_BUSY, 8'd0);
        expect_val(K_OUT, mem_m[2]);
        step();
        expect_val(K_RDY, 8'd0);
        expect_val(K_BUSY, 8'd0);
        for (int a = 0; a <= 3; a++) read_chk(8'(a));

        repeat (3) step();
        if (chk_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d checks / %0d done pending expected 0 / 0",
                     chk_q.size(), done_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
